// File: rtl/sram_port_ctrl.sv
// rtl/sram_port_ctrl.sv - valid/ready controller for a single-port masked-write SRAM macro
//
// Ports:
//   clk, reset_n            clock shared with the macro; synchronous active-low reset
//   req_v_i/req_ready_o     client request handshake; req_we_i selects write (1) or read (0)
//   req_addr_i/wdata/wmask  word address, write data, per-bit write enable
//   resp_v_o/resp_ready_i   read response handshake; resp_data_o is the FIFO head
//   init_done_o             zero-fill finished, client port open
//   ram_*_o                 registered macro pins (ce, we, addr, wd, wmask)
//   ram_rd_i                macro read data, valid two cycles after a read accept
module sram_port_ctrl #(
    parameter int BITS       = 96,
    parameter int WORD_DEPTH = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int RESP_DEPTH = 4,
    parameter int INIT_ZERO  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_v_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [BITS-1:0]       req_wdata_i,
    input  logic [BITS-1:0]       req_wmask_i,
    output logic                  resp_v_o,
    input  logic                  resp_ready_i,
    output logic [BITS-1:0]       resp_data_o,
    output logic                  init_done_o,
    output logic                  ram_ce_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [BITS-1:0]       ram_wd_o,
    output logic [BITS-1:0]       ram_wmask_o,
    input  logic [BITS-1:0]       ram_rd_i
);

    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam logic [ADDR_WIDTH:0] INIT_END   = (ADDR_WIDTH + 1)'(WORD_DEPTH);
    localparam logic [CNT_W-1:0]    CREDIT_MAX = CNT_W'(RESP_DEPTH);
    localparam logic [PTR_W-1:0]    PTR_LAST   = PTR_W'(RESP_DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH:0]     init_cnt_q;
    logic                    ram_ce_q;
    logic                    ram_we_q;
    logic [ADDR_WIDTH-1:0]   ram_addr_q;
    logic [BITS-1:0]         ram_wd_q;
    logic [BITS-1:0]         ram_wmask_q;

    logic [CNT_W-1:0]        credit_q, credit_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [1:0]              pend_q;
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [BITS-1:0]         fifo_q [RESP_DEPTH];

    logic run, accept, rd_accept, push, pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // A read is admitted only if a FIFO slot is reserved for it; writes never need one.
    assign run         = (state_q == ST_RUN);
    assign req_ready_o = run & (req_we_i | (credit_q != '0));
    assign accept      = req_v_i & req_ready_o;
    assign rd_accept   = accept & ~req_we_i;
    assign resp_v_o    = (count_q != '0);
    assign pop         = resp_v_o & resp_ready_i;
    assign push        = pend_q[1];
    assign resp_data_o = fifo_q[rd_ptr_q];
    assign init_done_o = run;

    assign ram_ce_o    = ram_ce_q;
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wd_o    = ram_wd_q;
    assign ram_wmask_o = ram_wmask_q;

    always_comb begin
        credit_d = credit_q;
        if (rd_accept && !pop) begin
            credit_d = credit_q - CNT_W'(1);
        end else if (pop && !rd_accept) begin
            credit_d = credit_q + CNT_W'(1);
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Mode FSM and macro pin registers. The init counter runs one past the last
    // address so the final zero write is held on the pins for a full cycle
    // before the client port opens.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
            init_cnt_q  <= '0;
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wd_q    <= '0;
            ram_wmask_q <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (init_cnt_q == INIT_END) begin
                        state_q  <= ST_RUN;
                        ram_ce_q <= 1'b0;
                        ram_we_q <= 1'b0;
                    end else begin
                        ram_ce_q    <= 1'b1;
                        ram_we_q    <= 1'b1;
                        ram_addr_q  <= init_cnt_q[ADDR_WIDTH-1:0];
                        ram_wd_q    <= '0;
                        ram_wmask_q <= '1;
                        init_cnt_q  <= init_cnt_q + (ADDR_WIDTH + 1)'(1);
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        ram_ce_q    <= 1'b1;
                        ram_we_q    <= req_we_i;
                        ram_addr_q  <= req_addr_i;
                        ram_wd_q    <= req_wdata_i;
                        ram_wmask_q <= req_wmask_i;
                    end else begin
                        ram_ce_q <= 1'b0;
                        ram_we_q <= 1'b0;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    // Read tracking and response FIFO. pend_q[0] = pins carry the read,
    // pend_q[1] = macro output holds the data; only then is ram_rd_i captured.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            credit_q <= CREDIT_MAX;
            count_q  <= '0;
            pend_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < RESP_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            credit_q <= credit_d;
            count_q  <= count_d;
            pend_q   <= {pend_q[0], rd_accept};
            if (push) begin
                fifo_q[wr_ptr_q] <= ram_rd_i;
                wr_ptr_q         <= ptr_next(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
        end
    end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb/tb_sram_port_ctrl.sv - directed self-checking bench for sram_port_ctrl
module tb_sram_port_ctrl;

    localparam int BITS = 96;
    localparam int WD   = 64;
    localparam int AW   = 6;
    localparam int RD   = 4;
    localparam logic [BITS-1:0] ONES   = '1;
    localparam logic [BITS-1:0] ZERO   = '0;
    localparam logic [BITS-1:0] MASK16 = 96'h0000_FFFF;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            req_v_i, req_ready_o, req_we_i;
    logic [AW-1:0]   req_addr_i;
    logic [BITS-1:0] req_wdata_i, req_wmask_i;
    logic            resp_v_o, resp_ready_i;
    logic [BITS-1:0] resp_data_o;
    logic            init_done_o;
    logic            ram_ce_o, ram_we_o;
    logic [AW-1:0]   ram_addr_o;
    logic [BITS-1:0] ram_wd_o, ram_wmask_o, ram_rd_i;

    logic            scramble;
    logic [BITS-1:0] mem [WD];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_port_ctrl #(
        .BITS(BITS), .WORD_DEPTH(WD), .ADDR_WIDTH(AW), .RESP_DEPTH(RD), .INIT_ZERO(1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wmask_i(req_wmask_i),
        .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i), .resp_data_o(resp_data_o),
        .init_done_o(init_done_o),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_wd_o(ram_wd_o), .ram_wmask_o(ram_wmask_o), .ram_rd_i(ram_rd_i)
    );

    // Macro model: masked write, one-cycle synchronous read; garbage-filled at start.
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < WD; i++) begin
                mem[i] <= {3{32'hDEAD_BEEF}} ^ BITS'(i);
            end
        end else if (ram_ce_o) begin
            if (ram_we_o) begin
                mem[ram_addr_o] <= (mem[ram_addr_o] & ~ram_wmask_o) | (ram_wd_o & ram_wmask_o);
            end else begin
                ram_rd_i <= mem[ram_addr_o];
            end
        end
    end

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [BITS-1:0] obs, input logic [BITS-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [BITS-1:0] d, input logic [BITS-1:0] m);
        req_v_i     = v;
        req_we_i    = we;
        req_addr_i  = a;
        req_wdata_i = d;
        req_wmask_i = m;
        #1;
    endtask

    initial begin
        reset_n = 1'b0; scramble = 1'b1; resp_ready_i = 1'b0;
        drive(1'b0, 1'b0, 6'd0, ZERO, ZERO);
        next_cycle();
        next_cycle();
        scramble = 1'b0;

        // Reset state
        chk_b("rst_ready", req_ready_o, 1'b0);
        chk_b("rst_resp_v", resp_v_o, 1'b0);
        chk_w("rst_resp_data", resp_data_o, ZERO);
        chk_b("rst_init_done", init_done_o, 1'b0);
        chk_b("rst_ce", ram_ce_o, 1'b0);
        chk_b("rst_we", ram_we_o, 1'b0);
        chk_a("rst_addr", ram_addr_o, 6'd0);
        chk_w("rst_wd", ram_wd_o, ZERO);
        chk_w("rst_wmask", ram_wmask_o, ZERO);

        // Zero-fill with a read of address 63 held pending
        reset_n = 1'b1; resp_ready_i = 1'b1;
        drive(1'b1, 1'b0, 6'd63, ZERO, ZERO);
        for (int i = 0; i < WD; i++) begin
            next_cycle();
            chk_b("init_ce", ram_ce_o, 1'b1);
            chk_b("init_we", ram_we_o, 1'b1);
            chk_a("init_addr", ram_addr_o, AW'(i));
            chk_w("init_wd", ram_wd_o, ZERO);
            chk_w("init_mask", ram_wmask_o, ONES);
            chk_b("init_ready_low", req_ready_o, 1'b0);
            chk_b("init_done_low", init_done_o, 1'b0);
        end
        next_cycle();
        chk_b("c65_init_done", init_done_o, 1'b1);
        chk_b("c65_ce_low", ram_ce_o, 1'b0);
        chk_b("c65_ready", req_ready_o, 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 6'd0, ZERO, ZERO);
        chk_b("rd63_pin_ce", ram_ce_o, 1'b1);
        chk_b("rd63_pin_we", ram_we_o, 1'b0);
        chk_a("rd63_pin_addr", ram_addr_o, 6'd63);
        next_cycle();
        chk_b("rd63_n2_resp_v", resp_v_o, 1'b0);
        next_cycle();
        chk_b("rd63_n3_resp_v", resp_v_o, 1'b1);
        chk_w("rd63_data_zero", resp_data_o, ZERO);
        next_cycle();
        chk_b("rd63_drained", resp_v_o, 1'b0);

        // Masked write then read
        drive(1'b1, 1'b1, 6'd5, ONES, MASK16);
        chk_b("mw_wr_ready", req_ready_o, 1'b1);
        next_cycle();
        drive(1'b1, 1'b0, 6'd5, ZERO, ZERO);
        chk_b("mw_rd_ready", req_ready_o, 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 6'd0, ZERO, ZERO);
        chk_b("mw_n1_resp_v", resp_v_o, 1'b0);
        next_cycle();
        chk_b("mw_n2_resp_v", resp_v_o, 1'b0);
        next_cycle();
        chk_b("mw_n3_resp_v", resp_v_o, 1'b1);
        chk_w("mw_data", resp_data_o, MASK16);
        next_cycle();
        chk_b("mw_drained", resp_v_o, 1'b0);

        // Throughput: pre-write value=addr, then 16 back-to-back reads
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 1'b1, AW'(k), BITS'(k), ONES);
            chk_b("tp_wr_ready", req_ready_o, 1'b1);
            next_cycle();
        end
        for (int c = 0; c < 19; c++) begin
            if (c < 16) begin
                drive(1'b1, 1'b0, AW'(c), ZERO, ZERO);
                chk_b("tp_rd_ready", req_ready_o, 1'b1);
            end else begin
                drive(1'b0, 1'b0, 6'd0, ZERO, ZERO);
            end
            if (c < 3) begin
                chk_b("tp_resp_v_early", resp_v_o, 1'b0);
            end else begin
                chk_b("tp_resp_v", resp_v_o, 1'b1);
                chk_w("tp_resp_data", resp_data_o, BITS'(c - 3));
            end
            next_cycle();
        end
        chk_b("tp_drained", resp_v_o, 1'b0);

        // Backpressure: four reads fill the credits, reads then stall, writes pass
        resp_ready_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            drive(1'b1, 1'b0, AW'(b), ZERO, ZERO);
            chk_b("bp_rd_ready", req_ready_o, 1'b1);
            next_cycle();
        end
        drive(1'b1, 1'b0, 6'd4, ZERO, ZERO);
        chk_b("bp_rd_blocked", req_ready_o, 1'b0);
        chk_b("bp_resp_v", resp_v_o, 1'b1);
        chk_w("bp_head_first", resp_data_o, ZERO);
        next_cycle();
        drive(1'b1, 1'b1, 6'd20, ONES, ONES);
        chk_b("bp_wr_ready", req_ready_o, 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 6'd0, ZERO, ZERO);
        next_cycle();
        chk_b("bp_stall_resp_v", resp_v_o, 1'b1);
        chk_w("bp_stall_head", resp_data_o, ZERO);
        resp_ready_i = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk_b("bp_drain_v", resp_v_o, 1'b1);
            chk_w("bp_drain_data", resp_data_o, BITS'(k));
            next_cycle();
        end
        chk_b("bp_drained", resp_v_o, 1'b0);

        // Pop and read request in the same cycle while credit is zero
        resp_ready_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0, AW'(10 + c), ZERO, ZERO);
            chk_b("pa_credit_back", req_ready_o, 1'b1);
            next_cycle();
        end
        drive(1'b1, 1'b0, 6'd14, ZERO, ZERO);
        for (int c = 0; c < 3; c++) begin
            chk_b("pa_blocked", req_ready_o, 1'b0);
            next_cycle();
        end
        resp_ready_i = 1'b1;
        #1;
        chk_b("pa_pop_v", resp_v_o, 1'b1);
        chk_w("pa_pop_data", resp_data_o, BITS'(10));
        chk_b("pa_same_cycle_blocked", req_ready_o, 1'b0);
        next_cycle();
        resp_ready_i = 1'b0;
        #1;
        chk_b("pa_next_cycle_ready", req_ready_o, 1'b1);
        chk_w("pa_head_next", resp_data_o, BITS'(11));
        next_cycle();
        drive(1'b1, 1'b0, 6'd15, ZERO, ZERO);
        chk_b("pa_credit_zero", req_ready_o, 1'b0);
        resp_ready_i = 1'b1;
        drive(1'b0, 1'b0, 6'd0, ZERO, ZERO);
        for (int k = 0; k < 4; k++) begin
            chk_b("pa_drain_v", resp_v_o, 1'b1);
            chk_w("pa_drain_data", resp_data_o, BITS'(11 + k));
            next_cycle();
        end
        chk_b("pa_drained", resp_v_o, 1'b0);

        // Reset with reads in flight and one response waiting
        resp_ready_i = 1'b0;
        for (int d = 0; d < 3; d++) begin
            drive(1'b1, 1'b0, AW'(1 + d), ZERO, ZERO);
            chk_b("mr_rd_ready", req_ready_o, 1'b1);
            next_cycle();
        end
        drive(1'b1, 1'b0, 6'd4, ZERO, ZERO);
        chk_b("mr_pre_resp_v", resp_v_o, 1'b1);
        chk_w("mr_pre_data", resp_data_o, BITS'(1));
        reset_n = 1'b0;
        next_cycle();
        chk_b("mr_resp_v_cleared", resp_v_o, 1'b0);
        chk_w("mr_data_cleared", resp_data_o, ZERO);
        chk_b("mr_init_done_low", init_done_o, 1'b0);
        chk_b("mr_ready_low", req_ready_o, 1'b0);
        chk_b("mr_ce_low", ram_ce_o, 1'b0);
        reset_n = 1'b1; resp_ready_i = 1'b1;
        drive(1'b0, 1'b0, 6'd0, ZERO, ZERO);
        for (int i = 0; i < WD; i++) begin
            next_cycle();
            chk_b("mr_init_ce", ram_ce_o, 1'b1);
            chk_a("mr_init_addr", ram_addr_o, AW'(i));
            chk_b("mr_no_stale", resp_v_o, 1'b0);
        end
        next_cycle();
        chk_b("mr_init_done", init_done_o, 1'b1);
        chk_b("mr_no_stale_after", resp_v_o, 1'b0);
        resp_ready_i = 1'b0;
        for (int e = 0; e < 4; e++) begin
            drive(1'b1, 1'b0, AW'(7 + e), ZERO, ZERO);
            chk_b("mr_credit_full", req_ready_o, 1'b1);
            next_cycle();
        end
        drive(1'b1, 1'b0, 6'd11, ZERO, ZERO);
        chk_b("mr_credit_limit", req_ready_o, 1'b0);
        next_cycle();
        resp_ready_i = 1'b1;
        drive(1'b0, 1'b0, 6'd0, ZERO, ZERO);
        for (int k = 0; k < 4; k++) begin
            chk_b("mr_drain_v", resp_v_o, 1'b1);
            chk_w("mr_drain_zero", resp_data_o, ZERO);
            next_cycle();
        end
        chk_b("mr_drained", resp_v_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
